// File: rtl/divisor_arbitro.sv
// divisor_arbitro: round-robin arbiter/sequencer sharing one sequential divider among M requesters.
// Latency: div_valid 1 cycle after accept; rsp_valid the cycle after div_done (3+2N cycles, 3 for B=0).
// Backpressure: req_ready only in IDLE; response regs held while rsp_ready[g] is low.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset (shared with the divider)
//   req_valid/req_ready    per-requester request handshake, operands packed as [i*N +: N]
//   req_a, req_b           dividend / divisor buses, one N-bit slice per requester
//   rsp_valid/rsp_ready    per-requester response handshake (one-hot rsp_valid)
//   rsp_q, rsp_r, rsp_error shared response bus, qualified by rsp_valid
//   busy                   high whenever the sequencer is not IDLE
//   div_*                  start/operand/result/done interface to the divider instance

module divisor_arbitro #(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   req_valid,
  input  logic [M*N-1:0] req_a,
  input  logic [M*N-1:0] req_b,
  output logic [M-1:0]   req_ready,
  output logic [M-1:0]   rsp_valid,
  input  logic [M-1:0]   rsp_ready,
  output logic [N-1:0]   rsp_q,
  output logic [N-1:0]   rsp_r,
  output logic           rsp_error,
  output logic           busy,
  output logic           div_valid,
  output logic [N-1:0]   div_a,
  output logic [N-1:0]   div_b,
  input  logic [N-1:0]   div_q,
  input  logic [N-1:0]   div_r,
  input  logic           div_done,
  input  logic           div_error
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } opnd_t;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         err;
  } res_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] g_q, g_d;
  opnd_t         opnd_q, opnd_d;
  res_t          res_q, res_d;

  logic [M-1:0]  req_ready_c;
  logic [M-1:0]  rsp_valid_c;
  logic          div_valid_c;

  // Unpacked views of the packed operand buses, indexed by requester.
  logic [N-1:0]  a_arr [M];
  logic [N-1:0]  b_arr [M];

  always_comb begin
    for (int k = 0; k < M; k++) begin
      a_arr[k] = req_a[k*N +: N];
      b_arr[k] = req_b[k*N +: N];
    end
  end

  // Round-robin search: first valid requester starting at ptr, wrapping modulo M.
  // The candidate index carries one extra bit so the wrap works for any M, not
  // only powers of two.
  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic [IW:0]   cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < M; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(M)) begin
        cand = cand - (IW+1)'(M);
      end
      if (!gnt_found && req_valid[cand[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

  // Pointer advances past the requester just served, so a continuously
  // requesting port is reached within M operations.
  logic [IW-1:0] g_next;
  assign g_next = (g_q == IW'(M-1)) ? '0 : g_q + IW'(1);

  // Next-state and handshake logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    opnd_d      = opnd_q;
    res_d       = res_q;
    req_ready_c = '0;
    rsp_valid_c = '0;
    div_valid_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // req_ready is only raised toward a valid requester, so raising it
        // is itself the transfer.
        if (gnt_found) begin
          req_ready_c[gnt_idx] = 1'b1;
          opnd_d.a             = a_arr[gnt_idx];
          opnd_d.b             = b_arr[gnt_idx];
          g_d                  = gnt_idx;
          state_d              = S_ISSUE;
        end
      end

      S_ISSUE: begin
        div_valid_c = 1'b1;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        // Operands stay on div_a/div_b through this cycle: the divider
        // checks B for zero at done, not at start.
        if (div_done) begin
          res_d.q   = div_q;
          res_d.r   = div_r;
          res_d.err = div_error;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid_c[g_q] = 1'b1;
        if (rsp_ready[g_q]) begin
          ptr_d   = g_next;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  logic drive_div;
  logic in_resp;

  assign drive_div = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign in_resp   = (state_q == S_RESP);

  // The state register already sits in IDLE during reset, but req_ready is
  // combinational from req_valid, so it is forced low while rst is held.
  assign req_ready = rst ? '0 : req_ready_c;
  assign rsp_valid = rsp_valid_c;
  assign div_valid = div_valid_c;
  assign busy      = (state_q != S_IDLE);

  assign div_a     = drive_div ? opnd_q.a : '0;
  assign div_b     = drive_div ? opnd_q.b : '0;

  assign rsp_q     = in_resp ? res_q.q   : '0;
  assign rsp_r     = in_resp ? res_q.r   : '0;
  assign rsp_error = in_resp ? res_q.err : 1'b0;

endmodule

// File: doc/divisor_arbitro.md
# divisor_arbitro

Round-robin arbiter and sequencer that shares one `divisor_secuencial` instance among M requesters. It accepts one division request at a time through a per-requester valid/ready handshake and holds the operands stable while the divider runs. It captures quotient, remainder and the divide-by-zero flag on the divider's `done`, then returns them to the granted requester with a response handshake. It sits between the requester blocks and the divider, which is instantiated alongside it and driven through the `div_*` ports.

## Interface
- `N`, 8: operand/result width; must match the divider's `N`.
- `M`, 2: number of requesters (2..8).
- `clk` in, 1: single clock shared with the divider.
- `rst` in, 1: reset, asynchronous and active-high. Shared with the divider.
- `req_valid` in, M: requester i has operands on its slice.
- `req_a` in, M*N: dividend; requester i occupies bits [i*N +: N].
- `req_b` in, M*N: divisor, same packing as `req_a`.
- `req_ready` out, M: one-hot accept strobe.
- `rsp_valid` out, M: one-hot; result available for requester i.
- `rsp_ready` in, M: requester i consumes the result.
- `rsp_q` out, N: quotient (shared bus, qualified by `rsp_valid`).
- `rsp_r` out, N: remainder (shared bus).
- `rsp_error` out, 1: divide-by-zero flag for the current response.
- `busy` out, 1: high in every state except IDLE.
- `div_valid` out, 1: start strobe to the divider.
- `div_a` out, N: dividend to the divider.
- `div_b` out, N: divisor to the divider.
- `div_q` in, N: quotient from the divider.
- `div_r` in, N: remainder from the divider.
- `div_done` in, 1: completion strobe from the divider.
- `div_error` in, 1: divide-by-zero flag from the divider.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the first i with `req_valid[i]`, searching from pointer `ptr` upward modulo M.
  - `req_ready[grant]` is driven combinationally; every other `req_ready` bit is 0.
  - On transfer (valid & ready): latch `a`, `b` and grant index `g`, then go to ISSUE.
- ISSUE: `div_valid`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - `div_a`/`div_b` are driven from the latched registers from ISSUE through the `div_done` cycle inclusive. The divider evaluates divide-by-zero from `B` at `done`, so the operands must stay stable that long.
  - When `div_done`=1: capture `div_q`, `div_r`, `div_error` into the response registers and go to RESP.
- RESP:
  - `rsp_valid[g]`=1 and the response registers are held until `rsp_ready[g]`.
  - On the handshake: `ptr` <= (g+1) mod M, then go to IDLE.
- Back-to-back operation: a new request may be granted in the IDLE cycle right after the RESP handshake. The divider is idle by then, because it returns to IDLE one cycle after `done`.
- Divide by zero: the request is forwarded unchanged. The response carries `rsp_error`=1, and Q/R are whatever the divider presents; requesters ignore them.
- `req_valid` may drop before it is granted, with no side effect. `rsp_ready` bits of non-granted requesters are ignored.
- `div_done` arriving outside WAIT is ignored.

## Timing
- Reset values: every output is 0, `ptr`=0, state=IDLE.
- Reset mid-operation aborts everything; no response is delivered. The divider is reset by the same `rst`.
- Latency counts from the accept edge (cycle 0):
  - `div_valid` at cycle 1.
  - Divider `done` at cycle 2+2N, which is cycle 18 for N=8.
  - For B=0, `done` is at cycle 2.
  - `rsp_valid` is asserted in the cycle after `done`: cycle 3+2N in general, cycle 19 for N=8, cycle 3 for B=0.
- Throughput: one operation per 3+2N+1 cycles at best (with `rsp_ready` held high).
- `req_ready` is asserted only in IDLE. Requests arriving during any other state wait and are not lost.
- Simultaneous requests are served strictly round-robin from `ptr`. A requester that holds `req_valid` continuously is served within M operations.

## Test plan
- Single op, N=8, M=2: req0 A=100, B=7, `rsp_ready` tied high -> `rsp_valid[0]` at cycle 19, Q=14, R=2, `rsp_error`=0, `busy` falls the next cycle.
- Divide by zero: req1 A=55, B=0 -> `rsp_valid[1]` at cycle 3, `rsp_error`=1; `div_b` stays 0 through the `done` cycle.
- Contention: both requesters valid continuously, req0 A=200/B=10 and req1 A=9/B=4, `ptr`=0 -> responses in order req0 (Q=20, R=0), req1 (Q=2, R=1), req0, ... with no starvation.
- Backpressure: `rsp_ready[0]` held low for 10 cycles after `rsp_valid[0]` rises -> Q/R/error stay stable, `req_ready` stays 0, and a pending req1 is granted in the cycle after the handshake.
- Reset mid-op: assert `rst` in WAIT -> all outputs 0 immediately (asynchronous), no `rsp_valid`. A fresh request A=255, B=1 then returns Q=255, R=0.
- Operand stability: change `req_a`/`req_b` during WAIT -> `div_a`/`div_b` unchanged and the result matches the latched operands.
